// File: rtl/wave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wave_pkg
// Description : Shared constants and FSM state type for the wave-profile
//               writer (producer side of the display's wave-profile bus).
// Contents    : N_SAMPLES_DEFAULT, CENTER_DEFAULT, SCREEN_H_DEFAULT, PHASE_W,
//               bus field widths, wave_state_t.
// Revision    : 1.0 - initial release
// ============================================================================
package wave_pkg;

    localparam int N_SAMPLES_DEFAULT = 1024;
    localparam int CENTER_DEFAULT    = 382;
    localparam int SCREEN_H_DEFAULT  = 768;
    localparam int PHASE_W           = 16;

    localparam int PROF_W   = 10;
    localparam int ADDR_W   = 10;
    localparam int OFFSET_W = 11;
    localparam int SCROLL_W = 4;
    localparam int AMP_W    = 8;
    localparam int SINE_W   = 8;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        STREAM     = 2'd1,
        DRAIN      = 2'd2
    } wave_state_t;

endpackage
`default_nettype wire

// File: rtl/wave_profile_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : wave_profile_writer_if
// Description : Wave-profile bus between the writer (master) and the pixel
//               display (slave).
// Signals     : wave_prof  - height sample
//               wave_addr  - sample index
//               wave_clk   - 1-cycle data-valid strobe
//               p_offset   - horizontal scroll offset of the frame
//               frame_done - pulse after the last sample of a frame
//               overrun    - sticky frame-start-while-busy flag
// Revision    : 1.0 - initial release
// ============================================================================
interface wave_profile_writer_if;
    import wave_pkg::*;

    logic [PROF_W-1:0]   wave_prof;
    logic [ADDR_W-1:0]   wave_addr;
    logic                wave_clk;
    logic [OFFSET_W-1:0] p_offset;
    logic                frame_done;
    logic                overrun;

    modport master (
        output wave_prof, wave_addr, wave_clk, p_offset, frame_done, overrun
    );

    modport slave (
        input wave_prof, wave_addr, wave_clk, p_offset, frame_done, overrun
    );

endinterface
`default_nettype wire

// File: rtl/sine_lut.sv
`default_nettype none
// ============================================================================
// Module      : sine_lut
// Description : 256-point signed sine, amplitude 127, built from a 65-entry
//               quarter-wave table with quadrant mirroring. Output registered.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset
//               addr - phase[15:8]; bits 7:6 quadrant, bits 5:0 index
//               sine - registered 8-bit signed sample
// Revision    : 1.0 - initial release
// ============================================================================
module sine_lut
    import wave_pkg::*;
(
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic [7:0]               addr,
    output logic signed [SINE_W-1:0]      sine
);

    // round(127 * sin(pi * k / 128)), k = 0..64
    function automatic logic [6:0] quarter(input logic [6:0] k);
        logic [6:0] v;
        v = 7'd0;
        case (k)
            7'd0:  v = 7'd0;   7'd1:  v = 7'd3;   7'd2:  v = 7'd6;   7'd3:  v = 7'd9;
            7'd4:  v = 7'd12;  7'd5:  v = 7'd16;  7'd6:  v = 7'd19;  7'd7:  v = 7'd22;
            7'd8:  v = 7'd25;  7'd9:  v = 7'd28;  7'd10: v = 7'd31;  7'd11: v = 7'd34;
            7'd12: v = 7'd37;  7'd13: v = 7'd40;  7'd14: v = 7'd43;  7'd15: v = 7'd46;
            7'd16: v = 7'd49;  7'd17: v = 7'd51;  7'd18: v = 7'd54;  7'd19: v = 7'd57;
            7'd20: v = 7'd60;  7'd21: v = 7'd63;  7'd22: v = 7'd65;  7'd23: v = 7'd68;
            7'd24: v = 7'd71;  7'd25: v = 7'd73;  7'd26: v = 7'd76;  7'd27: v = 7'd78;
            7'd28: v = 7'd81;  7'd29: v = 7'd83;  7'd30: v = 7'd85;  7'd31: v = 7'd88;
            7'd32: v = 7'd90;  7'd33: v = 7'd92;  7'd34: v = 7'd94;  7'd35: v = 7'd96;
            7'd36: v = 7'd98;  7'd37: v = 7'd100; 7'd38: v = 7'd102; 7'd39: v = 7'd104;
            7'd40: v = 7'd106; 7'd41: v = 7'd107; 7'd42: v = 7'd109; 7'd43: v = 7'd111;
            7'd44: v = 7'd112; 7'd45: v = 7'd113; 7'd46: v = 7'd115; 7'd47: v = 7'd116;
            7'd48: v = 7'd117; 7'd49: v = 7'd118; 7'd50: v = 7'd120; 7'd51: v = 7'd121;
            7'd52: v = 7'd122; 7'd53: v = 7'd122; 7'd54: v = 7'd123; 7'd55: v = 7'd124;
            7'd56: v = 7'd125; 7'd57: v = 7'd125; 7'd58: v = 7'd126; 7'd59: v = 7'd126;
            7'd60: v = 7'd126; 7'd61: v = 7'd127; 7'd62: v = 7'd127; 7'd63: v = 7'd127;
            7'd64: v = 7'd127;
            default: v = 7'd0;
        endcase
        return v;
    endfunction

    logic [1:0] w_quad;
    logic [5:0] w_idx;
    logic [6:0] w_k;
    logic [7:0] w_mag;

    assign w_quad = addr[7:6];
    assign w_idx  = addr[5:0];
    // Odd quadrants run the table backwards; k = 64 is reachable only there.
    assign w_k    = w_quad[0] ? (7'd64 - {1'b0, w_idx}) : {1'b0, w_idx};
    assign w_mag  = {1'b0, quarter(w_k)};

    always_ff @(posedge clk) begin
        if (rst) begin
            sine <= '0;
        end else begin
            sine <= w_quad[1] ? $signed(-w_mag) : $signed(w_mag);
        end
    end

endmodule
`default_nettype wire

// File: rtl/wave_profile_writer.sv
`default_nettype none
// ============================================================================
// Module      : wave_profile_writer
// Description : Once per frame (vsync falling edge) streams N_SAMPLES surface
//               heights CENTER + (sin(phase) * amplitude) >>> 7 onto the
//               wave-profile bus, and advances the horizontal scroll offset.
// Ports       : vclock       - pixel clock
//               reset        - synchronous active-high reset
//               vsync        - active-low vertical sync
//               scroll_speed - per-frame scroll advance
//               freq_step    - per-sample phase increment
//               amplitude    - unsigned wave amplitude
//               prof         - wave-profile bus (master modport)
// Options     : WAVE_CLAMP_EN - saturate heights to [0, SCREEN_H-1]
// Revision    : 1.0 - initial release
// ============================================================================
module wave_profile_writer
    import wave_pkg::*;
#(
    parameter int N_SAMPLES = N_SAMPLES_DEFAULT,
`ifdef WAVE_CLAMP_EN
    parameter int SCREEN_H  = SCREEN_H_DEFAULT,
`endif
    parameter int CENTER    = CENTER_DEFAULT
)(
    input  wire logic                  vclock,
    input  wire logic                  reset,
    input  wire logic                  vsync,
    input  wire logic [SCROLL_W-1:0]   scroll_speed,
    input  wire logic [PHASE_W-1:0]    freq_step,
    input  wire logic [AMP_W-1:0]      amplitude,
    wave_profile_writer_if.master      prof
);

    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(N_SAMPLES - 1);

    // ---------------- control ----------------
    wave_state_t          r_state, w_state_next;
    logic                 r_vsync_d;
    logic                 w_frame_start;
    logic                 r_drain_cnt;
    logic [PHASE_W-1:0]   r_frame_phase;
    logic [PHASE_W-1:0]   r_phase;
    logic [ADDR_W-1:0]    r_idx;
    logic [PHASE_W-1:0]   r_freq_sh;
    logic [AMP_W-1:0]     r_amp_sh;
    logic [OFFSET_W-1:0]  r_p_offset;
    logic                 r_overrun;
    logic [PHASE_W-1:0]   w_scroll_step;
    logic [PHASE_W-1:0]   w_frame_phase_next;
    logic                 w_issue;
    logic                 w_issue_last;

    assign w_frame_start      = r_vsync_d & ~vsync;
    assign w_scroll_step      = {{(PHASE_W-SCROLL_W){1'b0}}, scroll_speed} * freq_step;
    assign w_frame_phase_next = r_frame_phase + w_scroll_step;
    assign w_issue            = (r_state == STREAM);
    assign w_issue_last       = w_issue && (r_idx == c_last_idx);

    always_ff @(posedge vclock) begin
        if (reset) begin
            r_state <= WAIT_FRAME;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            WAIT_FRAME: if (w_frame_start) w_state_next = STREAM;
            STREAM:     if (r_idx == c_last_idx) w_state_next = DRAIN;
            DRAIN:      if (r_drain_cnt) w_state_next = WAIT_FRAME;
            default:    w_state_next = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge vclock) begin
        if (reset) begin
            r_vsync_d     <= 1'b0;
            r_drain_cnt   <= 1'b0;
            r_frame_phase <= '0;
            r_phase       <= '0;
            r_idx         <= '0;
            r_freq_sh     <= '0;
            r_amp_sh      <= '0;
            r_p_offset    <= '0;
            r_overrun     <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
            unique case (r_state)
                WAIT_FRAME: begin
                    if (w_frame_start) begin
                        r_freq_sh     <= freq_step;
                        r_amp_sh      <= amplitude;
                        r_p_offset    <= r_p_offset + {{(OFFSET_W-SCROLL_W){1'b0}}, scroll_speed};
                        r_frame_phase <= w_frame_phase_next;
                        r_phase       <= w_frame_phase_next;
                        r_idx         <= '0;
                        r_drain_cnt   <= 1'b0;
                    end
                end
                STREAM: begin
                    r_phase <= r_phase + r_freq_sh;
                    r_idx   <= r_idx + 1'b1;
                    if (w_frame_start) r_overrun <= 1'b1;
                end
                DRAIN: begin
                    r_drain_cnt <= ~r_drain_cnt;
                    if (w_frame_start) r_overrun <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- stage 1: LUT read ----------------
    logic signed [SINE_W-1:0] w_sine;
    logic                     r_s1_valid, r_s1_last;
    logic [ADDR_W-1:0]        r_s1_addr;

    sine_lut u_sine_lut (
        .clk  (vclock),
        .rst  (reset),
        .addr (r_phase[PHASE_W-1:PHASE_W-8]),
        .sine (w_sine)
    );

    // ---------------- stage 2: scale and offset ----------------
    logic signed [15:0] w_sine_ext, w_amp_ext, w_s, w_s_sh;
    logic signed [11:0] w_h, r_h;
    logic               r_s2_valid, r_s2_last;
    logic [ADDR_W-1:0]  r_s2_addr;

    assign w_sine_ext = {{8{w_sine[SINE_W-1]}}, w_sine};
    assign w_amp_ext  = {8'd0, r_amp_sh};
    assign w_s        = w_sine_ext * w_amp_ext;
    assign w_s_sh     = w_s >>> 7;
    // |s >>> 7| <= 254, so the low 12 bits carry the full value.
    assign w_h        = $signed(12'(CENTER) + w_s_sh[11:0]);

    // ---------------- output formatting ----------------
    logic [PROF_W-1:0] w_prof;
    logic              w_unused;

`ifdef WAVE_CLAMP_EN
    localparam logic signed [11:0] c_h_max = 12'(SCREEN_H - 1);

    always_comb begin
        w_prof = r_h[PROF_W-1:0];
        if (r_h < 12'sd0) begin
            w_prof = '0;
        end else if (r_h > c_h_max) begin
            w_prof = c_h_max[PROF_W-1:0];
        end
    end
    assign w_unused = ^{1'b0, w_s_sh[15:12]};
`else
    assign w_prof   = r_h[PROF_W-1:0];
    assign w_unused = ^{1'b0, w_s_sh[15:12], r_h[11:10]};
`endif

    // ---------------- pipeline registers ----------------
    logic [PROF_W-1:0] r_wave_prof;
    logic [ADDR_W-1:0] r_wave_addr;
    logic              r_wave_clk, r_out_last, r_frame_done;

    always_ff @(posedge vclock) begin
        if (reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_addr    <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_last    <= 1'b0;
            r_s2_addr    <= '0;
            r_h          <= '0;
            r_wave_prof  <= '0;
            r_wave_addr  <= '0;
            r_wave_clk   <= 1'b0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_s1_valid <= w_issue;
            r_s1_last  <= w_issue_last;
            r_s1_addr  <= r_idx;

            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_addr  <= r_s1_addr;
            r_h        <= w_h;

            r_wave_clk <= r_s2_valid;
            r_out_last <= r_s2_valid & r_s2_last;
            if (r_s2_valid) begin
                r_wave_prof <= w_prof;
                r_wave_addr <= r_s2_addr;
            end
            // One cycle after the final strobe leaves the output register.
            r_frame_done <= r_wave_clk & r_out_last;
        end
    end

    assign prof.wave_prof  = r_wave_prof;
    assign prof.wave_addr  = r_wave_addr;
    assign prof.wave_clk   = r_wave_clk;
    assign prof.p_offset   = r_p_offset;
    assign prof.frame_done = r_frame_done;
    assign prof.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_wave_profile_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wave_profile_writer
// Description : Self-checking bench for wave_profile_writer. Heights are
//               predicted from a real-valued sine with rounding and floor
//               division; frame phase and scroll offset are tracked as plain
//               running sums.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_profile_writer;

    logic        vclock = 1'b0;
    logic        reset;
    logic        vsync;
    logic [3:0]  scroll_speed;
    logic [15:0] freq_step;
    logic [7:0]  amplitude;

    always #5 vclock = ~vclock;

    wave_profile_writer_if prof_if ();

    wave_profile_writer dut (
        .vclock       (vclock),
        .reset        (reset),
        .vsync        (vsync),
        .scroll_speed (scroll_speed),
        .freq_step    (freq_step),
        .amplitude    (amplitude),
        .prof         (prof_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned m_fp;      // accumulated frame phase
    int          m_po;      // accumulated scroll offset

    function automatic int model_sin(input int p8);
        real r;
        r = 127.0 * $sin(2.0 * 3.14159265358979 * p8 / 256.0);
        if (r >= 0.0) return $rtoi(r + 0.5);
        else          return -$rtoi(-r + 0.5);
    endfunction

    function automatic int model_height(input int unsigned phase, input int am);
        int prod, q, h;
        prod = model_sin(int'((phase >> 8) & 255)) * am;
        q = prod / 128;
        if (prod < 0 && (prod % 128) != 0) q = q - 1;
        h = 382 + q;
`ifdef WAVE_CLAMP_EN
        if (h < 0) h = 0;
        if (h > 767) h = 767;
        return h;
`else
        return h & 1023;
`endif
    endfunction

    // ---------------- frame capture ----------------
    int cap_prof [0:1023];
    int cap_addr [0:1023];
    int cap_n, first_cyc, last_cyc, done_cyc;

    task automatic run_frame(input logic [3:0] sc, input logic [15:0] fs,
                             input logic [7:0] am, input int extra_at,
                             input int reset_at, input string tag);
        int cyc, errs, bad_i;
        bit done;
        int unsigned base;
        @(negedge vclock);
        scroll_speed = sc; freq_step = fs; amplitude = am; vsync = 1'b0;
        m_fp = (m_fp + int'(sc) * int'(fs)) & 32'hFFFF;
        m_po = (m_po + int'(sc)) & 2047;
        base = m_fp;
        @(negedge vclock);
        vsync = 1'b1;
        // Inputs changing mid-frame must not disturb the stream.
        scroll_speed = 4'($urandom); freq_step = 16'($urandom); amplitude = 8'($urandom);
        cap_n = 0; done = 1'b0; cyc = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
        while (!done && cyc < 1300) begin
            @(negedge vclock);
            cyc++;
            if (prof_if.wave_clk) begin
                if (cap_n < 1024) begin
                    cap_prof[cap_n] = int'(prof_if.wave_prof);
                    cap_addr[cap_n] = int'(prof_if.wave_addr);
                end
                if (first_cyc < 0) first_cyc = cyc;
                cap_n++;
                last_cyc = cyc;
            end
            if (prof_if.frame_done) begin
                done = 1'b1;
                done_cyc = cyc;
            end
            vsync = (extra_at >= 0 && cap_n == extra_at) ? 1'b0 : 1'b1;
            if (reset_at >= 0 && cap_n == reset_at) begin
                reset = 1'b1;
                @(negedge vclock);
                check({tag, " rst wave_clk"},   prof_if.wave_clk, 0);
                check({tag, " rst wave_prof"},  prof_if.wave_prof, 0);
                check({tag, " rst wave_addr"},  prof_if.wave_addr, 0);
                check({tag, " rst p_offset"},   prof_if.p_offset, 0);
                check({tag, " rst overrun"},    prof_if.overrun, 0);
                check({tag, " rst frame_done"}, prof_if.frame_done, 0);
                reset = 1'b0;
                m_fp = 0; m_po = 0;
                return;
            end
        end
        vsync = 1'b1;
        check({tag, " frame_done seen"}, done, 1);
        check({tag, " strobe count"}, cap_n, 1024);
        check({tag, " first strobe latency"}, first_cyc, 3);
        check({tag, " done after last"}, done_cyc - last_cyc, 1);
        check({tag, " p_offset"}, prof_if.p_offset, m_po);
        errs = 0; bad_i = -1;
        for (int i = 0; i < 1024 && i < cap_n; i++) begin
            if (cap_addr[i] != i ||
                cap_prof[i] != model_height((base + i * int'(fs)) & 32'hFFFF, int'(am))) begin
                errs++;
                if (bad_i < 0) bad_i = i;
            end
        end
        check({tag, " sample errors"}, errs, 0);
        if (bad_i >= 0)
            $display("  first bad sample %0d: addr %0d prof %0d, model %0d", bad_i,
                     cap_addr[bad_i], cap_prof[bad_i],
                     model_height((base + bad_i * int'(fs)) & 32'hFFFF, int'(am)));
        repeat (3) @(negedge vclock);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [3:0]  sc;
        logic [15:0] fs;
        logic [7:0]  am;
        int          addr;
        int          exp_prof;
    } vec_t;

    vec_t vecs [0:7];

    initial begin
        int clk_cnt;
        int f1_s5;

        vecs[0] = '{4'd0, 16'h0100, 8'd0,   0,   382};
        vecs[1] = '{4'd0, 16'h0100, 8'd0,   700, 382};
        vecs[2] = '{4'd0, 16'h0100, 8'd127, 0,   382};
        vecs[3] = '{4'd0, 16'h0100, 8'd127, 64,  508};
        vecs[4] = '{4'd0, 16'h0100, 8'd127, 128, 382};
        vecs[5] = '{4'd0, 16'h0100, 8'd127, 192, 255};
        vecs[6] = '{4'd0, 16'h0100, 8'd64,  64,  445};
        vecs[7] = '{4'd0, 16'h0100, 8'd64,  192, 318};

        m_fp = 0; m_po = 0;
        reset = 1'b1; vsync = 1'b1;
        scroll_speed = '0; freq_step = '0; amplitude = '0;
        repeat (5) @(negedge vclock);
        reset = 1'b0;

        clk_cnt = 0;
        repeat (10) begin
            @(negedge vclock);
            if (prof_if.wave_clk) clk_cnt++;
        end
        check("idle wave_clk count", clk_cnt, 0);
        check("reset wave_prof", prof_if.wave_prof, 0);
        check("reset wave_addr", prof_if.wave_addr, 0);
        check("reset p_offset", prof_if.p_offset, 0);
        check("reset frame_done", prof_if.frame_done, 0);
        check("reset overrun", prof_if.overrun, 0);

        for (int v = 0; v < 8; v++) begin
            run_frame(vecs[v].sc, vecs[v].fs, vecs[v].am, -1, -1, $sformatf("vec%0d", v));
            check($sformatf("vec%0d prof@%0d", v, vecs[v].addr),
                  cap_prof[vecs[v].addr], vecs[v].exp_prof);
        end

        // Scroll accumulation: offsets 5, 10, 15; phase shifts by 5 samples per frame.
        run_frame(4'd5, 16'h0100, 8'd100, -1, -1, "scroll1");
        check("scroll1 p_offset", prof_if.p_offset, 5);
        f1_s5 = cap_prof[5];
        run_frame(4'd5, 16'h0100, 8'd100, -1, -1, "scroll2");
        check("scroll2 p_offset", prof_if.p_offset, 10);
        check("scroll2 addr0 vs frame1 addr5", cap_prof[0], f1_s5);
        run_frame(4'd5, 16'h0100, 8'd100, -1, -1, "scroll3");
        check("scroll3 p_offset", prof_if.p_offset, 15);

        for (int r = 0; r < 4; r++) begin
            run_frame(4'($urandom_range(0, 15)), 16'($urandom), 8'($urandom), -1, -1,
                      $sformatf("rand%0d", r));
        end

        // Frame start while streaming: flagged, sticky, stream unaffected.
        check("overrun before", prof_if.overrun, 0);
        run_frame(4'd3, 16'h0321, 8'd200, 100, -1, "overrun");
        check("overrun set", prof_if.overrun, 1);
        run_frame(4'd1, 16'h1000, 8'd50, -1, -1, "after_overrun");
        check("overrun sticky", prof_if.overrun, 1);

        // Reset mid-stream.
        run_frame(4'd2, 16'h0200, 8'd90, -1, 500, "midreset");
        clk_cnt = 0;
        repeat (10) begin
            @(negedge vclock);
            if (prof_if.wave_clk) clk_cnt++;
        end
        check("post-reset wave_clk count", clk_cnt, 0);
        run_frame(4'($urandom_range(0, 15)), 16'($urandom), 8'($urandom), -1, -1, "recover");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wave_profile_writer.md
Name: wave_profile_writer

Overview:
Producer end of the wave-profile interface consumed by the pixel display.
- Once per video frame, on the start of vsync, streams N_SAMPLES 10-bit surface heights (wave_prof), one per horizontal sample, each qualified by the wave_clk strobe.
- Also drives the frame's horizontal scroll offset (p_offset).
- Heights come from a phase-accumulated sine scaled by an amplitude, so the wave scrolls smoothly frame to frame.

Parameters:
N_SAMPLES, 1024, samples streamed per frame (depth of the display's profile buffer)
CENTER, 382, vertical rest line of the wave, in pixels
SCREEN_H, 768, visible lines; used by the clamp feature

Ports:
vclock  input  1  65 MHz pixel clock, sole clock
reset  input  1  synchronous, active-high
vsync  input  1  active-low vertical sync from the video timing generator
scroll_speed  input  4  pixels/phase steps advanced per frame
freq_step  input  16  phase increment per sample
amplitude  input  8  unsigned wave amplitude
wave_prof  output  10  height sample (row of the surface at this sample)
wave_addr  output  10  index of the sample on wave_prof
wave_clk  output  1  1-cycle data-valid strobe, synchronous to vclock
p_offset  output  11  horizontal scroll offset for this frame
frame_done  output  1  1-cycle pulse after the last sample of a frame
overrun  output  1  sticky; set if a frame start arrives while still streaming

Behaviour:
- Reset values: wave_prof=0, wave_addr=0, wave_clk=0, p_offset=0, frame_done=0, overrun=0. Internal frame_phase=0, FSM=WAIT_FRAME.
- Reset mid-stream aborts the stream: wave_clk is low from the next edge on.
- Frame start: vsync was 1 last cycle and is 0 this cycle (registered edge detect). Frame starts are acted on only in WAIT_FRAME.
- FSM states:
  - WAIT_FRAME: on frame start, latch scroll_speed/freq_step/amplitude into shadow registers, then:
    - p_offset <= p_offset + scroll_speed (11-bit wrap)
    - frame_phase <= frame_phase + scroll_speed*freq_step (16-bit wrap)
    - phase <= updated frame_phase; idx <= 0
    - go to STREAM
  - STREAM: each cycle, issue sample idx (phase <= phase + freq_step; idx++). After issuing idx = N_SAMPLES-1, go to DRAIN.
  - DRAIN: 2 cycles to empty the pipeline, then pulse frame_done and go to WAIT_FRAME.
- A frame start seen in STREAM or DRAIN sets overrun and is otherwise ignored. Only reset clears overrun.
- Input changes during a stream have no effect until the next frame start (shadow registers).
- Sine LUT:
  - Address is phase[15:8]: quadrant q = bits 7:6, index i = bits 5:0.
  - Table T[0..64] holds round(127*sin(pi*k/128)).
  - Output by quadrant: q0 → T[i]; q1 → T[64-i]; q2 → -T[i]; q3 → -T[64-i].
  - Result is 8-bit signed.
- Pipeline: stage 1 is a registered LUT read. Stage 2 is a registered multiply/add:
  - s = sin * amplitude, 16-bit signed, amplitude zero-extended
  - h = CENTER + (s >>> 7), 12-bit signed; the arithmetic shift floors toward minus infinity.
- Output timing: wave_prof, wave_addr and wave_clk are registered and mutually aligned. The first wave_clk occurs 3 cycles after the first STREAM cycle.
- wave_clk is high for exactly N_SAMPLES consecutive cycles per frame.
- Output width: without the clamp feature, wave_prof = h[9:0].

Optional Feature:
WAVE_CLAMP_EN
- Defined: h is saturated to [0, SCREEN_H-1] before output.
- Undefined: plain 10-bit truncation, no compare logic.

Decomposition:
- Shared package wave_pkg holds:
  - constants N_SAMPLES_DEFAULT, CENTER_DEFAULT, SCREEN_H_DEFAULT, PHASE_W=16
  - FSM state typedef {WAIT_FRAME, STREAM, DRAIN}
- One sub-module, sine_lut: quarter-wave table plus quadrant mirroring, with a registered output.

Test Plan:
- Reset held, then released with vsync=1 → all outputs 0, no wave_clk.
- amplitude=0, freq_step=0x0100, one vsync fall → 1024 strobes, all wave_prof=382, wave_addr 0..1023 in order, frame_done 1 cycle after the last strobe.
- amplitude=127, freq_step=0x0100, scroll_speed=0 → addr 0: 382; addr 64: 508; addr 128: 382; addr 192: 255.
- scroll_speed=5, three frames → p_offset 5, 10, 15. With freq_step=0x0100, frame 2 addr 0 equals frame 1 addr 5.
- Extra vsync fall during STREAM → overrun=1 and sticky, stream completes with 1024 strobes. Reset at strobe 500 → wave_clk low the next cycle, all outputs 0.
- WAVE_CLAMP_EN defined, CENTER=700, amplitude=255, freq_step=0x0100 → addr 64 gives 767 (unclamped 953).
